// File: rtl/conv_acc_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_acc_sequencer
//
// Accumulation sequencer for the convolution accelerator's FP adder path.
// Products arrive one at a time on a valid/ready handshake. Each product is
// issued to an external floating-point adder as op_a, with the running
// partial sum of the current window as op_b. The adder result becomes the new
// partial sum. After TERMS products the window sum is held on out_data until
// downstream accepts it. No arithmetic is done here; data are opaque
// DATA_W-bit patterns (IEEE-754 single by default).
//
// Ports
//   clk               system clock, rising edge active
//   rst               asynchronous reset, active low
//   clear             synchronous flush of the current window (also clears err)
//   in_data/in_valid  incoming product, accepted when in_ready is high
//   in_ready          high only in IDLE
//   op_a/op_b         adder operands (product / running sum), held while waiting
//   add_valid         one-cycle issue strobe to the adder
//   add_result(_valid) adder sum, any latency of one cycle or more
//   out_data/out_valid completed window sum, held until out_ready
//   out_ready         downstream accepts out_data
//   term_count        products accumulated in the current window
//   busy              high in any state other than IDLE
//   err               sticky flag: adder result arrived when none was expected
// -----------------------------------------------------------------------------
module conv_acc_sequencer #(
  parameter int DATA_W = 32,
  parameter int TERMS  = 9,
  parameter int CNT_W  = $clog2(TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              add_valid,
  input  logic [DATA_W-1:0] add_result,
  input  logic              add_result_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  term_count,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TERMS_C = CNT_W'(TERMS);

  state_t state_q, state_d;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              add_valid_q, add_valid_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Event decode. clear outranks every event, so each qualifies on !clear.
  logic             accept;
  logic             res_any;
  logic             res_take;
  logic             res_drop;
  logic             res_bad;
  logic             out_take;
  logic [CNT_W-1:0] cnt_inc;
  logic             last;

  always_comb begin
    accept   = (state_q == S_IDLE) && in_valid && !clear;
    res_any  = add_result_valid && !clear;
    // A pending drop swallows the next result wherever it lands, even in WAIT:
    // that result belongs to the flushed window, not the current one.
    res_take = res_any && (state_q == S_WAIT) && !drop_q;
    res_drop = res_any && drop_q;
    res_bad  = res_any && (state_q != S_WAIT) && !drop_q;
    out_take = (state_q == S_DONE) && out_ready && !clear;
    cnt_inc  = cnt_q + CNT_W'(1);
    last     = (cnt_inc == TERMS_C);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) state_d = S_WAIT;
        S_WAIT: if (res_take) state_d = last ? S_DONE : S_IDLE;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs decoded from state
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

  // Control next-state
  always_comb begin
    add_valid_d = accept;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    if (clear) begin
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      cnt_d       = '0;
      // A result landing on the clear cycle is discarded with it, so only arm
      // the drop when the in-flight result is still outstanding.
      if ((state_q == S_WAIT) && !add_result_valid) begin
        drop_d = 1'b1;
      end else if (add_result_valid) begin
        drop_d = 1'b0;
      end
    end else begin
      if (res_drop) drop_d = 1'b0;
      if (res_bad)  err_d  = 1'b1;
      if (res_take) begin
        cnt_d = cnt_inc;
        if (last) out_valid_d = 1'b1;
      end
      if (out_take) begin
        out_valid_d = 1'b0;
        cnt_d       = '0;
      end
    end
  end

  // Data next-state
  always_comb begin
    acc_d      = acc_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    out_data_d = out_data_q;
    if (clear) begin
      acc_d = '0;
    end else if (res_take) begin
      acc_d = add_result;
    end else if (out_take) begin
      acc_d = '0;
    end
    if (accept) begin
      op_a_d = in_data;
      op_b_d = acc_q;
    end
    if (res_take && last) begin
      out_data_d = add_result;
    end
  end

  // Register stage: control and data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_data_q  <= '0;
    end else begin
      add_valid_q <= add_valid_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_data_q  <= out_data_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign add_valid  = add_valid_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign term_count = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_conv_acc_sequencer.sv
`timescale 1ns/1ps
module tb_conv_acc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear;

  // DUT with TERMS=3
  logic [31:0] in_data, op_a, op_b, add_result, out_data;
  logic        in_valid, in_ready, add_valid, add_result_valid;
  logic        out_valid, out_ready, busy, err;
  logic [1:0]  term_count;

  // DUT with TERMS=1
  logic [31:0] in_data1, op_a1, op_b1, add_result1, out_data1;
  logic        in_valid1, in_ready1, add_valid1, add_result_valid1;
  logic        out_valid1, out_ready1, busy1, err1;
  logic [0:0]  term_count1;

  conv_acc_sequencer #(.DATA_W(32), .TERMS(3)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .add_valid(add_valid),
    .add_result(add_result), .add_result_valid(add_result_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .term_count(term_count), .busy(busy), .err(err)
  );

  conv_acc_sequencer #(.DATA_W(32), .TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .add_valid(add_valid1),
    .add_result(add_result1), .add_result_valid(add_result_valid1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .term_count(term_count1), .busy(busy1), .err(err1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Single-precision <-> real conversion for normal numbers and zero.
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Adder models (they ignore rst so that a stale result can outlive a reset)
  int          lat3 = 2;
  bit          rand_mode = 1'b0;
  int          pend3 = 0, pend1 = 0;
  logic [31:0] res3, md3 = '0, res1, md1 = '0;
  logic        mv3 = 1'b0, mv1 = 1'b0;
  logic        inj_v = 1'b0;
  logic [31:0] inj_d = '0;

  always @(posedge clk) begin
    mv3 <= 1'b0;
    if (pend3 > 0) begin
      pend3 <= pend3 - 1;
      if (pend3 == 1) begin
        mv3 <= 1'b1;
        md3 <= res3;
      end
    end
    if (add_valid) begin
      res3  <= fp_add(op_a, op_b);
      pend3 <= rand_mode ? int'($urandom_range(1, 4)) : lat3;
    end
  end

  always @(posedge clk) begin
    mv1 <= 1'b0;
    if (pend1 > 0) begin
      pend1 <= pend1 - 1;
      if (pend1 == 1) begin
        mv1 <= 1'b1;
        md1 <= res1;
      end
    end
    if (add_valid1) begin
      res1  <= fp_add(op_a1, op_b1);
      pend1 <= 2;
    end
  end

  assign add_result_valid  = mv3 | inj_v;
  assign add_result        = inj_v ? inj_d : md3;
  assign add_result_valid1 = mv1;
  assign add_result1       = md1;

  logic or_dir = 1'b1, rr = 1'b1;
  always @(negedge clk) rr <= ($urandom_range(0, 3) != 0);
  assign out_ready  = rand_mode ? rr : or_dir;
  assign out_ready1 = 1'b1;

  // Reference model: a window is a list of products; op_b of each issue is
  // the in-order sum of the products already in the window.
  logic [31:0] window[$];
  logic [31:0] q_opa[$], q_opb[$], q_out[$];
  logic [31:0] q1_opa[$], q1_opb[$], q1_out[$];

  function automatic logic [31:0] window_sum();
    logic [31:0] s;
    s = 32'd0;
    foreach (window[i]) s = fp_add(s, window[i]);
    return s;
  endfunction

  task automatic accept3(input logic [31:0] d);
    q_opa.push_back(d);
    q_opb.push_back(window_sum());
    window.push_back(d);
    if (window.size() == 3) begin
      q_out.push_back(window_sum());
      window.delete();
    end
  endtask

  task automatic accept1(input logic [31:0] d);
    q1_opa.push_back(d);
    q1_opb.push_back(32'd0);
    q1_out.push_back(d);
  endtask

  // Monitors
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      if (add_valid) begin
        if (q_opb.size() == 0) fail("unexpected_issue");
        else begin
          chk("op_a", op_a, q_opa.pop_front());
          chk("op_b", op_b, q_opb.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (q_out.size() == 0) fail("unexpected_output");
        else begin
          chk("out_data", out_data, q_out.pop_front());
          chk("term_count_done", 32'(term_count), 32'd3);
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      if (add_valid1) begin
        if (q1_opb.size() == 0) fail("t1_unexpected_issue");
        else begin
          chk("t1_op_a", op_a1, q1_opa.pop_front());
          chk("t1_op_b", op_b1, q1_opb.pop_front());
        end
      end
      if (out_valid1 && out_ready1) begin
        if (q1_out.size() == 0) fail("t1_unexpected_output");
        else chk("t1_out_data", out_data1, q1_out.pop_front());
      end
    end
  end

  // Stimulus helpers (called at a falling edge, return at a falling edge)
  task automatic send(input bit sel, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    if (sel) begin in_data1 = d; in_valid1 = 1'b1; end
    else     begin in_data  = d; in_valid  = 1'b1; end
    for (int n = 0; n < 300; n++) begin
      if ((sel ? in_ready1 : in_ready) && !clear) begin
        ok = 1'b1;
        if (sel) accept1(d); else accept3(d);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    if (!ok) fail("send_timeout");
  endtask

  task automatic wait_out(input bit sel);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (sel ? out_valid1 : out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail("wait_out_timeout");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (in_ready && !out_valid && !add_result_valid && pend3 == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail("wait_idle_timeout");
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    window.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;

  initial begin
    rst = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_data = '0;
    in_valid1 = 1'b0; in_data1 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_add_valid", 32'(add_valid), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_term_count", 32'(term_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: three ones -> 3.0
    repeat (3) send(0, ONE);
    wait_out(0);
    chk("s1_out_data", out_data, THREE);
    chk("s1_out_valid", 32'(out_valid), 1);
    chk("s1_term_count", 32'(term_count), 3);
    @(negedge clk);
    wait_idle();

    // 2: back-pressure, upstream presents data while DONE
    or_dir = 1'b0;
    repeat (3) send(0, ONE);
    wait_out(0);
    in_data = 32'h1234_5678;
    in_valid = 1'b1;
    repeat (5) begin
      chk("s2_hold_valid", 32'(out_valid), 1);
      chk("s2_hold_data", out_data, THREE);
      chk("s2_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    or_dir = 1'b1;
    @(negedge clk);
    repeat (3) send(0, TWO);
    wait_out(0);
    chk("s2_next_window", out_data, 32'h40C0_0000);
    @(negedge clk);
    wait_idle();

    // 3: clear in WAIT of term 2 drops the in-flight result
    lat3 = 4;
    send(0, ONE);
    send(0, ONE);
    pulse_clear();
    repeat (8) @(negedge clk);
    chk("s3_err", 32'(err), 0);
    chk("s3_term_count", 32'(term_count), 0);
    lat3 = 2;
    repeat (3) send(0, TWO);
    wait_out(0);
    chk("s3_out_data", out_data, 32'h40C0_0000);
    @(negedge clk);
    wait_idle();

    // 4: spurious result in IDLE mid-window
    send(0, ONE);
    wait_idle();
    inj_d = 32'h7F7F_0000;
    inj_v = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
    chk("s4_err_set", 32'(err), 1);
    repeat (3) @(negedge clk);
    chk("s4_err_sticky", 32'(err), 1);
    repeat (2) send(0, ONE);
    wait_out(0);
    chk("s4_out_data", out_data, THREE);
    @(negedge clk);
    wait_idle();
    chk("s4_err_still", 32'(err), 1);
    pulse_clear();
    chk("s4_err_cleared", 32'(err), 0);

    // 5: asynchronous reset mid-WAIT, late result afterwards
    lat3 = 6;
    send(0, ONE);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("s5_op_a", op_a, 0);
    chk("s5_op_b", op_b, 0);
    chk("s5_out_data", out_data, 0);
    chk("s5_add_valid", 32'(add_valid), 0);
    chk("s5_out_valid", 32'(out_valid), 0);
    chk("s5_term_count", 32'(term_count), 0);
    chk("s5_busy", 32'(busy), 0);
    window.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (err) break;
      @(negedge clk);
    end
    chk("s5_late_err", 32'(err), 1);
    wait_idle();
    pulse_clear();
    chk("s5_err_cleared", 32'(err), 0);
    lat3 = 2;

    // 6: TERMS=1
    send(1, 32'h4049_0FDB);
    wait_out(1);
    chk("s6_out0", out_data1, 32'h4049_0FDB);
    @(negedge clk);
    send(1, 32'hBF80_0000);
    wait_out(1);
    chk("s6_out1", out_data1, 32'hBF80_0000);
    repeat (3) @(negedge clk);

    // Random windows with random latency and back-pressure
    rand_mode = 1'b1;
    for (int w = 0; w < 25; w++) begin
      for (int t = 0; t < 3; t++) begin
        int v;
        v = int'($urandom_range(1, 200));
        if ($urandom_range(0, 1) == 1) v = -v;
        send(0, r2f(real'(v)));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    for (int n = 0; n < 200; n++) begin
      if (q_out.size() == 0) break;
      @(negedge clk);
    end
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);

    chk("end_err", 32'(err), 0);
    chk("end_q_opb", 32'(q_opb.size()), 0);
    chk("end_q_out", 32'(q_out.size()), 0);
    chk("end_q1_out", 32'(q1_out.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
